// File: rtl/apv_frame_decoder_if.sv
// Purpose : bundles the sample input and decoded-frame outputs of one APV channel decoder.
// Latency : none (wiring only).
// Backpressure: none; the sample source cannot be stalled.
interface apv_frame_decoder_if;
    logic [11:0] SAMPLE_IN;
    logic        SAMPLE_VALID;
    logic [11:0] DATA_OUT;
    logic        DATA_VALID;
    logic [6:0]  DATA_IDX;
    logic        FRAME_START;
    logic [7:0]  HDR_ADDR;
    logic        HDR_ERR;
    logic        FRAME_END;
    logic        LOCKED;
    logic        SYNC_ERR;
    logic [15:0] FRAME_CNT;

    // Sample source side (deserializer / testbench driver)
    modport master (
        output SAMPLE_IN, SAMPLE_VALID,
        input  DATA_OUT, DATA_VALID, DATA_IDX, FRAME_START, HDR_ADDR, HDR_ERR,
        input  FRAME_END, LOCKED, SYNC_ERR, FRAME_CNT
    );

    // Decoder side
    modport slave (
        input  SAMPLE_IN, SAMPLE_VALID,
        output DATA_OUT, DATA_VALID, DATA_IDX, FRAME_START, HDR_ADDR, HDR_ERR,
        output FRAME_END, LOCKED, SYNC_ERR, FRAME_CNT
    );
endinterface

// File: rtl/apv_frame_decoder.sv
// Purpose : lock onto APV sync ticks, parse frame headers, emit 128 indexed analog samples per frame.
// Latency : every output is registered, 1 CLK after the valid sample that causes it.
// Backpressure: none; SAMPLE_VALID low holds all state and zeroes the pulse outputs.
module apv_frame_decoder #(
    parameter logic [11:0] THRESHOLD   = 12'h800,
    parameter int          TICK_PERIOD = 35,
    parameter int          LOCK_TICKS  = 4,
    parameter int          N_SAMPLES   = 128
) (
    input  logic               CLK,
    input  logic               RSTn,
    apv_frame_decoder_if.slave bus
);
    localparam int PER_W = $clog2(2*TICK_PERIOD + 2);
    localparam int LCK_W = $clog2(LOCK_TICKS + 1);
    localparam int CNT_W = $clog2(N_SAMPLES + 9);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_H1   = 3'd1;
    localparam logic [2:0] S_H2   = 3'd2;
    localparam logic [2:0] S_ADDR = 3'd3;
    localparam logic [2:0] S_ERRB = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_SKIP = 3'd6;

    localparam logic [PER_W-1:0] PER_TGT   = PER_W'(TICK_PERIOD);
    localparam logic [PER_W-1:0] LOSS_LIM  = PER_W'(2*TICK_PERIOD);
    localparam logic [LCK_W-1:0] LOCK_MAX  = LCK_W'(LOCK_TICKS);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(N_SAMPLES + 8);

    // frame FSM
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_addr_sh;
    // tick tracking
    logic [PER_W-1:0] r_per;       // samples since last tick's first high, 1 on the sample after it
    logic             r_per_vld;
    logic             r_pend_vld;  // interval of the tick currently in H1 was measurable
    logic             r_pend_ok;   // ...and equalled TICK_PERIOD
    logic [PER_W-1:0] r_low;       // low samples since the last high (hunting states only)
    logic [LCK_W-1:0] r_lockcnt;
    // registered outputs
    logic [11:0]      r_data_out;
    logic             r_data_vld;
    logic [6:0]       r_data_idx;
    logic             r_frame_start;
    logic [7:0]       r_hdr_addr;
    logic             r_hdr_err;
    logic             r_frame_end;
    logic             r_sync_err;
    logic [15:0]      r_frame_cnt;

    logic             w_h;
    logic             w_locked;
    logic             w_hunt;
    logic             w_body_done;
    logic             w_lock_loss;
    logic [PER_W-1:0] w_per_inc;
    logic [PER_W-1:0] w_low_inc;

    assign w_h         = (bus.SAMPLE_IN > THRESHOLD);
    assign w_locked    = (r_lockcnt == LOCK_MAX);
    assign w_hunt      = (r_state == S_IDLE) || (r_state == S_H1) || (r_state == S_H2);
    assign w_body_done = ((r_state == S_DATA) && (r_cnt == DATA_LAST)) ||
                         ((r_state == S_SKIP) && (r_cnt == SKIP_LAST));
    // long silence in IDLE while locked: this low is the (2*TICK_PERIOD+1)-th since the last high
    assign w_lock_loss = (r_state == S_IDLE) && !w_h && w_locked && (r_low >= LOSS_LIM);
    assign w_per_inc   = (r_per == '1) ? r_per : r_per + 1'b1;
    assign w_low_inc   = (r_low == '1) ? r_low : r_low + 1'b1;

    assign bus.DATA_OUT    = r_data_out;
    assign bus.DATA_VALID  = r_data_vld;
    assign bus.DATA_IDX    = r_data_idx;
    assign bus.FRAME_START = r_frame_start;
    assign bus.HDR_ADDR    = r_hdr_addr;
    assign bus.HDR_ERR     = r_hdr_err;
    assign bus.FRAME_END   = r_frame_end;
    assign bus.LOCKED      = w_locked;
    assign bus.SYNC_ERR    = r_sync_err;
    assign bus.FRAME_CNT   = r_frame_cnt;

    // Tick spacing, lock counting, silence detection and SYNC_ERR generation
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_per      <= '0;
            r_per_vld  <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_ok  <= 1'b0;
            r_low      <= '0;
            r_lockcnt  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            if (bus.SAMPLE_VALID) begin
                r_per <= w_per_inc;
                // first high of a tick or header: measure interval, restart the period count
                if ((r_state == S_IDLE) && w_h) begin
                    r_pend_vld <= r_per_vld;
                    r_pend_ok  <= (r_per == PER_TGT);
                    r_per      <= PER_W'(1);
                    r_per_vld  <= 1'b1;
                end
                // a frame or skipped frame breaks the tick cadence; next tick only re-arms
                if (w_body_done) begin
                    r_per_vld <= 1'b0;
                end

                if (w_body_done || (w_hunt && w_h)) begin
                    r_low <= '0;
                end else if (w_hunt) begin
                    r_low <= w_low_inc;
                end

                // tick confirmed (single high): apply the interval measured at its first high
                if ((r_state == S_H1) && !w_h && r_pend_vld) begin
                    if (!r_pend_ok) begin
                        r_lockcnt <= '0;
                    end else if (!w_locked) begin
                        r_lockcnt <= r_lockcnt + 1'b1;
                    end
                end else if (w_lock_loss) begin
                    r_lockcnt <= '0;
                end else if ((r_state == S_SKIP) && (r_cnt == SKIP_LAST)) begin
                    r_lockcnt <= '0;
                end

                r_sync_err <= ((r_state == S_H2) && !w_h) || w_lock_loss;
            end
        end
    end

    // Frame FSM: header qualification, address/error capture, indexed sample output
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr_sh     <= '0;
            r_data_out    <= '0;
            r_data_vld    <= 1'b0;
            r_data_idx    <= '0;
            r_frame_start <= 1'b0;
            r_hdr_addr    <= '0;
            r_hdr_err     <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_data_vld    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            if (bus.SAMPLE_VALID) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_h) r_state <= S_H1;
                    end
                    S_H1: begin
                        r_state <= w_h ? S_H2 : S_IDLE;
                    end
                    S_H2: begin
                        r_cnt <= '0;
                        if (!w_h)          r_state <= S_IDLE;
                        else if (w_locked) r_state <= S_ADDR;
                        else               r_state <= S_SKIP;
                    end
                    S_ADDR: begin
                        r_addr_sh <= {r_addr_sh[6:0], w_h};
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == ADDR_LAST) r_state <= S_ERRB;
                    end
                    S_ERRB: begin
                        r_hdr_addr    <= r_addr_sh;
                        r_hdr_err     <= w_h;
                        r_frame_start <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                        r_cnt         <= '0;
                        r_state       <= S_DATA;
                    end
                    S_DATA: begin
                        r_data_out <= bus.SAMPLE_IN;
                        r_data_vld <= 1'b1;
                        r_data_idx <= r_cnt[6:0];
                        r_cnt      <= r_cnt + 1'b1;
                        if (r_cnt == DATA_LAST) begin
                            r_frame_end <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                    S_SKIP: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == SKIP_LAST) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_apv_frame_decoder.sv
// Purpose : self-checking bench for apv_frame_decoder (reference model + lock table + directed corner cases).
// Latency : outputs compared 1 CLK after each sample.
// Backpressure: SAMPLE_VALID gaps are inserted at random in parts of the run.
module tb_apv_frame_decoder;
    localparam logic [11:0] HI = 12'hB00;
    localparam logic [11:0] LO = 12'h200;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    apv_frame_decoder_if bus();

    apv_frame_decoder dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int gap_pct  = 0;

    // DUT observations gathered by the monitor
    int         obs_dv, obs_dv_bad, obs_fs, obs_fe, obs_fe_bad, obs_serr;
    logic [7:0] obs_addr;
    logic       obs_err;

    // reference model state: absolute sample positions rather than counters
    int          m_n, m_last_tick, m_last_high, m_run, m_body_left, m_lockcnt, m_pend;
    bit          m_body_lk;
    logic [7:0]  m_addr_sh;
    logic [11:0] e_dout;
    logic        e_dv, e_fs, e_err, e_fe, e_serr;
    logic [6:0]  e_idx;
    logic [7:0]  e_addr;
    logic [15:0] e_fcnt;

    typedef struct {
        int          nticks;
        int          spacing;
        logic [11:0] level;
        bit          exp_locked;
    } lock_vec_t;
    lock_vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [48:0] dut_word();
        return {bus.DATA_OUT, bus.DATA_VALID, bus.DATA_IDX, bus.FRAME_START, bus.HDR_ADDR,
                bus.HDR_ERR, bus.FRAME_END, bus.LOCKED, bus.SYNC_ERR, bus.FRAME_CNT};
    endfunction

    function automatic logic [48:0] exp_word();
        return {e_dout, e_dv, e_idx, e_fs, e_addr, e_err, e_fe, (m_lockcnt == 4), e_serr, e_fcnt};
    endfunction

    task automatic model_reset();
        m_n = 0; m_last_tick = -1; m_last_high = 0; m_run = 0; m_body_left = 0;
        m_lockcnt = 0; m_pend = -1; m_body_lk = 0; m_addr_sh = '0;
        e_dout = '0; e_dv = 0; e_idx = '0; e_fs = 0; e_addr = '0; e_err = 0;
        e_fe = 0; e_serr = 0; e_fcnt = '0;
    endtask

    // One valid sample through the protocol rules
    task automatic model_step(input logic [11:0] s);
        bit h;
        int pos;
        h = (s > 12'h800);
        e_dv = 0; e_fs = 0; e_fe = 0; e_serr = 0;
        m_n++;
        if (m_body_left > 0) begin
            pos = 137 - m_body_left;
            m_body_left--;
            if (m_body_lk) begin
                if (pos < 8) m_addr_sh = {m_addr_sh[6:0], h};
                else if (pos == 8) begin
                    e_fs = 1; e_addr = m_addr_sh; e_err = h; e_fcnt = e_fcnt + 16'd1;
                end else begin
                    e_dv = 1; e_idx = 7'(pos - 9); e_dout = s; e_fe = (pos - 9 == 127);
                end
            end
            if (m_body_left == 0) begin
                m_last_tick = -1;
                m_last_high = m_n;
                if (!m_body_lk) m_lockcnt = 0;
            end
        end else if (h) begin
            m_last_high = m_n;
            if (m_run == 0) begin
                m_pend = (m_last_tick < 0) ? -1 : m_n - m_last_tick;
                m_last_tick = m_n;
                m_run = 1;
            end else if (m_run == 1) begin
                m_run = 2;
            end else begin
                m_run = 0;
                m_body_left = 137;
                m_body_lk = (m_lockcnt == 4);
            end
        end else begin
            if (m_run == 1) begin
                if (m_pend == 35) m_lockcnt = (m_lockcnt < 4) ? m_lockcnt + 1 : 4;
                else if (m_pend >= 0) m_lockcnt = 0;
            end else if (m_run == 2) begin
                e_serr = 1;
            end else if (m_lockcnt == 4 && (m_n - m_last_high) > 70) begin
                m_lockcnt = 0;
                e_serr = 1;
            end
            m_run = 0;
        end
    endtask

    // Monitor: advance the model on each edge, compare all outputs, gather observations
    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (!RSTn) model_reset();
            else if (bus.SAMPLE_VALID) model_step(bus.SAMPLE_IN);
            else begin e_dv = 0; e_fs = 0; e_fe = 0; e_serr = 0; end
            #1;
            check("model_outputs", 64'(dut_word()), 64'(exp_word()));
            if (RSTn) begin
                if (bus.DATA_VALID) begin
                    obs_dv++;
                    if (bus.DATA_OUT != {5'd0, bus.DATA_IDX}) obs_dv_bad++;
                end
                if (bus.FRAME_START) begin obs_fs++; obs_addr = bus.HDR_ADDR; obs_err = bus.HDR_ERR; end
                if (bus.FRAME_END) begin
                    obs_fe++;
                    if (!(bus.DATA_VALID && bus.DATA_IDX == 7'd127)) obs_fe_bad++;
                end
                if (bus.SYNC_ERR) obs_serr++;
            end
        end
    end

    task automatic clear_obs();
        obs_dv = 0; obs_dv_bad = 0; obs_fs = 0; obs_fe = 0; obs_fe_bad = 0; obs_serr = 0;
    endtask

    task automatic send(input logic [11:0] s);
        if (gap_pct > 0) begin
            while ($urandom_range(99) < gap_pct) begin
                @(negedge CLK);
                bus.SAMPLE_VALID = 1'b0;
                bus.SAMPLE_IN    = 12'($urandom);
            end
        end
        @(negedge CLK);
        bus.SAMPLE_IN    = s;
        bus.SAMPLE_VALID = 1'b1;
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        bus.SAMPLE_VALID = 1'b0;
        bus.SAMPLE_IN    = '0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic tick_lv(input int sp, input logic [11:0] lv);
        send(lv);
        repeat (sp - 1) send(LO);
    endtask

    task automatic frame(input logic [7:0] addr, input bit err, input int ndata, input bit rnd);
        repeat (3) send(HI);
        for (int i = 7; i >= 0; i--) send(addr[i] ? HI : LO);
        send(err ? HI : LO);
        for (int i = 0; i < ndata; i++) send(rnd ? 12'($urandom) : 12'(i));
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    initial begin
        #5ms;
        n_checks++;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        finish_run();
    end

    initial begin
        bus.SAMPLE_IN    = '0;
        bus.SAMPLE_VALID = 1'b0;
        clear_obs();

        vecs[0] = '{5, 35, HI,      1'b1};
        vecs[1] = '{4, 35, HI,      1'b0};
        vecs[2] = '{5, 34, HI,      1'b0};
        vecs[3] = '{5, 36, HI,      1'b0};
        vecs[4] = '{7, 35, HI,      1'b1};
        vecs[5] = '{5, 35, 12'h800, 1'b0};
        vecs[6] = '{5, 35, 12'h801, 1'b1};

        // lock acquisition table
        foreach (vecs[v]) begin
            do_reset();
            clear_obs();
            repeat (vecs[v].nticks) tick_lv(vecs[v].spacing, vecs[v].level);
            settle();
            check($sformatf("lock_vec%0d_locked", v), 64'(bus.LOCKED), 64'(vecs[v].exp_locked));
            check($sformatf("lock_vec%0d_sync_err", v), 64'(obs_serr), 64'd0);
        end

        // reset state
        do_reset();
        check("reset_outputs", 64'(dut_word()), 64'd0);

        // single frame while locked; LOCKED rises 1 CLK after the 5th tick's confirm
        repeat (4) tick_lv(35, HI);
        send(HI); settle();
        check("lock_before_confirm", 64'(bus.LOCKED), 64'd0);
        send(LO); settle();
        check("lock_after_confirm", 64'(bus.LOCKED), 64'd1);
        repeat (33) send(LO);
        clear_obs();
        frame(8'h55, 1'b0, 128, 1'b0);
        settle();
        check("single_fs_count", 64'(obs_fs), 64'd1);
        check("single_hdr_addr", 64'(obs_addr), 64'h55);
        check("single_hdr_err", 64'(obs_err), 64'd0);
        check("single_dv_count", 64'(obs_dv), 64'd128);
        check("single_dout_eq_idx", 64'(obs_dv_bad), 64'd0);
        check("single_fe_count", 64'(obs_fe), 64'd1);
        check("single_fe_at_127", 64'(obs_fe_bad), 64'd0);
        check("single_frame_cnt", 64'(bus.FRAME_CNT), 64'd1);

        // three back-to-back frames with SAMPLE_VALID gaps
        do_reset();
        repeat (5) tick_lv(35, HI);
        clear_obs();
        gap_pct = 30;
        frame(8'hA3, 1'b1, 128, 1'b0);
        frame(8'h0F, 1'b0, 128, 1'b0);
        frame(8'hC6, 1'b1, 128, 1'b0);
        gap_pct = 0;
        settle();
        check("b2b_fs_count", 64'(obs_fs), 64'd3);
        check("b2b_fe_count", 64'(obs_fe), 64'd3);
        check("b2b_dv_count", 64'(obs_dv), 64'd384);
        check("b2b_dout_eq_idx", 64'(obs_dv_bad), 64'd0);
        check("b2b_last_addr", 64'(bus.HDR_ADDR), 64'hC6);
        check("b2b_last_err", 64'(bus.HDR_ERR), 64'd1);
        check("b2b_frame_cnt", 64'(bus.FRAME_CNT), 64'd3);
        check("b2b_locked", 64'(bus.LOCKED), 64'd1);

        // after frames: first tick only re-arms, a 34-sample interval then drops lock
        tick_lv(35, HI);
        tick_lv(34, HI);
        settle();
        check("lock_hold_after_frame", 64'(bus.LOCKED), 64'd1);
        send(HI); send(LO); settle();
        check("bad_spacing_unlock", 64'(bus.LOCKED), 64'd0);

        // two highs then low
        send(HI); send(HI); send(LO); settle();
        check("h2_low_sync_err", 64'(bus.SYNC_ERR), 64'd1);
        send(LO); settle();
        check("sync_err_one_cycle", 64'(bus.SYNC_ERR), 64'd0);

        // header while unlocked is skipped; relock starts again from zero
        do_reset();
        repeat (3) tick_lv(35, HI);
        clear_obs();
        frame(8'hFF, 1'b1, 128, 1'b1);
        settle();
        check("unlocked_no_dv", 64'(obs_dv), 64'd0);
        check("unlocked_no_fs", 64'(obs_fs), 64'd0);
        repeat (4) tick_lv(35, HI);
        settle();
        check("relock_not_yet", 64'(bus.LOCKED), 64'd0);
        tick_lv(35, HI);
        settle();
        check("relock_done", 64'(bus.LOCKED), 64'd1);

        // silence: 70 lows since the last high hold lock, the 71st drops it
        do_reset();
        repeat (5) tick_lv(35, HI);
        clear_obs();
        repeat (36) send(LO);
        settle();
        check("silence70_locked", 64'(bus.LOCKED), 64'd1);
        check("silence70_no_err", 64'(obs_serr), 64'd0);
        send(LO); settle();
        check("silence71_unlock", 64'(bus.LOCKED), 64'd0);
        check("silence71_sync_err", 64'(bus.SYNC_ERR), 64'd1);

        // reset in the middle of a frame
        do_reset();
        repeat (5) tick_lv(35, HI);
        clear_obs();
        frame(8'h3C, 1'b1, 61, 1'b0);
        settle();
        check("midframe_idx", 64'(bus.DATA_IDX), 64'd60);
        RSTn = 1'b0;
        bus.SAMPLE_VALID = 1'b0;
        #1;
        check("midframe_reset_outputs", 64'(dut_word()), 64'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (80) send(LO);
        settle();
        check("midframe_no_frame_end", 64'(obs_fe), 64'd0);

        // randomized traffic against the reference model
        do_reset();
        gap_pct = 20;
        for (int k = 0; k < 160; k++) begin
            case ($urandom_range(11))
                0, 1, 2, 3, 4: tick_lv(35, HI);
                5:             tick_lv($urandom_range(30, 40), HI);
                6, 7:          frame(8'($urandom), 1'($urandom), 128, 1'b1);
                8:             repeat ($urandom_range(1, 80)) send(LO);
                9:             begin send(HI); send(HI); send(LO); end
                10:            repeat (5) tick_lv(35, 12'($urandom_range(12'h801, 12'hFFF)));
                default:       repeat ($urandom_range(1, 10)) send(12'($urandom));
            endcase
        end
        gap_pct = 0;
        @(negedge CLK);
        bus.SAMPLE_VALID = 1'b0;
        repeat (3) settle();
        finish_run();
    end
endmodule
